alu_issue_ctrl: RTL and testbench

//  Decode/issue/writeback controller that sits directly upstream of the 16-bit ALU.
//  - Accepts 16-bit instruction words over a valid/ready handshake.
//  - Reads operands from an internal 8x16 register file and drives the ALU a/b/alu_op inputs.
//  - Captures the ALU's 32-bit result, writes bits [15:0] back to the register file and updates flags.
//  - Four-state FSM: one instruction in flight, throughput 1 instruction per 4 cycles.

---
 rtl/alu_issue_ctrl_pkg.sv | 47 ++++
 rtl/alu_issue_ctrl_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: widths, opcodes, FSM states and
// instruction field positions.
package alu_issue_ctrl_pkg;

   localparam int unsigned DataW = 16;
   localparam int unsigned NRegs = 8;
   localparam int unsigned AddrW = 3;
   localparam int unsigned ImmW  = 9;

   // Opcodes. 0001..1010 go to the ALU, 1011 loads an immediate, 1100..1111 are undefined.
   localparam logic [3:0] OpNop = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0001;
   localparam logic [3:0] OpSub = 4'b0010;
   localparam logic [3:0] OpAnd = 4'b0011;
   localparam logic [3:0] OpOr  = 4'b0100;
   localparam logic [3:0] OpXor = 4'b0101;
   localparam logic [3:0] OpShl = 4'b0110;
   localparam logic [3:0] OpShr = 4'b0111;
   localparam logic [3:0] OpMul = 4'b1000;
   localparam logic [3:0] OpLt  = 4'b1001;
   localparam logic [3:0] OpEq  = 4'b1010;
   localparam logic [3:0] OpLdi = 4'b1011;

   // Instruction field bit positions
   localparam int unsigned OpMsb  = 15;
   localparam int unsigned OpLsb  = 12;
   localparam int unsigned RdMsb  = 11;
   localparam int unsigned RdLsb  = 9;
   localparam int unsigned Rs1Msb = 8;
   localparam int unsigned Rs1Lsb = 6;
   localparam int unsigned Rs2Msb = 5;
   localparam int unsigned Rs2Lsb = 3;
   localparam int unsigned ImmMsb = 8;
   localparam int unsigned ImmLsb = 0;

   typedef enum logic [1:0] {
      StIdle,
      StDecode,
      StExec,
      StWb
   } state_e;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OpAdd) && (op <= OpEq);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 8x16 register file with r0 hardwired to zero.
// Ports:
//   clk, rst_n            clock, async active-low clear of all entries
//   raddr_a_i/rdata_a_o   async read port A
//   raddr_b_i/rdata_b_o   async read port B
//   dbg_addr_i/dbg_data_o async debug read port
//   we_i/waddr_i/wdata_i  synchronous write port; writes to r0 are dropped
module alu_issue_ctrl_regfile
   import alu_issue_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AddrW-1:0] raddr_a_i,
   output logic [DataW-1:0] rdata_a_o,
   input  logic [AddrW-1:0] raddr_b_i,
   output logic [DataW-1:0] rdata_b_o,
   input  logic [AddrW-1:0] dbg_addr_i,
   output logic [DataW-1:0] dbg_data_o,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i
);

   logic [DataW-1:0] mem_q [NRegs];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NRegs; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = (raddr_a_i == '0)  ? '0 : mem_q[raddr_a_i];
   assign rdata_b_o  = (raddr_b_i == '0)  ? '0 : mem_q[raddr_b_i];
   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode/issue/writeback controller in front of a 16-bit combinational ALU.
// One instruction in flight: IDLE -> DECODE -> [EXEC] -> WB -> IDLE.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   instr_valid_i/instr_ready_o   instruction handshake; ready only in IDLE
//   instr_i                       instruction word
//   alu_a_o/alu_b_o/alu_op_o      ALU operands and opcode, driven only in EXEC
//   alu_result_i                  ALU result (only [16:0] is used)
//   wb_valid_o/wb_addr_o/wb_data_o  writeback pulse, destination and value
//   zero_flag_o/carry_flag_o      flags of the last ALU op
//   illegal_op_o                  one-cycle pulse for an undefined opcode
//   dbg_addr_i/dbg_data_o         debug register read
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  logic [15:0]      instr_i,
   output logic [DataW-1:0] alu_a_o,
   output logic [DataW-1:0] alu_b_o,
   output logic [3:0]       alu_op_o,
   input  logic [31:0]      alu_result_i,
   output logic             wb_valid_o,
   output logic [AddrW-1:0] wb_addr_o,
   output logic [DataW-1:0] wb_data_o,
   output logic             zero_flag_o,
   output logic             carry_flag_o,
   output logic             illegal_op_o,
   input  logic [AddrW-1:0] dbg_addr_i,
   output logic [DataW-1:0] dbg_data_o
);

   state_e           state_q;
   logic [15:0]      instr_q;
   logic             instr_ready_q;
   logic [DataW-1:0] alu_a_q;
   logic [DataW-1:0] alu_b_q;
   logic [3:0]       alu_op_q;
   logic             wb_valid_q;
   logic [AddrW-1:0] wb_addr_q;
   logic [DataW-1:0] wb_data_q;
   logic             wb_alu_q;
   logic             wb_carry_q;
   logic             illegal_q;
   logic             zero_q;
   logic             carry_q;

   logic [3:0]       op;
   logic [AddrW-1:0] rd;
   logic [AddrW-1:0] rs1;
   logic [AddrW-1:0] rs2;
   logic [ImmW-1:0]  imm9;
   logic [DataW-1:0] rs1_data;
   logic [DataW-1:0] rs2_data;

   assign op   = instr_q[OpMsb:OpLsb];
   assign rd   = instr_q[RdMsb:RdLsb];
   assign rs1  = instr_q[Rs1Msb:Rs1Lsb];
   assign rs2  = instr_q[Rs2Msb:Rs2Lsb];
   assign imm9 = instr_q[ImmMsb:ImmLsb];

   // Upper result bits belong to wide ALU ops (e.g. multiply) and are not written back.
   logic unused_alu_hi;
   assign unused_alu_hi = ^alu_result_i[31:17];

   alu_issue_ctrl_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .raddr_a_i  (rs1),
      .rdata_a_o  (rs1_data),
      .raddr_b_i  (rs2),
      .rdata_b_o  (rs2_data),
      .dbg_addr_i (dbg_addr_i),
      .dbg_data_o (dbg_data_o),
      .we_i       (wb_valid_q),
      .waddr_i    (wb_addr_q),
      .wdata_i    (wb_data_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         instr_q       <= '0;
         instr_ready_q <= 1'b1;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         wb_valid_q    <= 1'b0;
         wb_addr_q     <= '0;
         wb_data_q     <= '0;
         wb_alu_q      <= 1'b0;
         wb_carry_q    <= 1'b0;
         illegal_q     <= 1'b0;
         zero_q        <= 1'b0;
         carry_q       <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (instr_valid_i && instr_ready_q) begin
                  instr_q       <= instr_i;
                  instr_ready_q <= 1'b0;
                  state_q       <= StDecode;
               end
            end
            StDecode: begin
               if (is_alu_op(op)) begin
                  // rf cannot change before EXEC, so operands are captured here.
                  alu_a_q  <= rs1_data;
                  alu_b_q  <= rs2_data;
                  alu_op_q <= op;
                  state_q  <= StExec;
               end else if (op == OpLdi) begin
                  wb_valid_q <= 1'b1;
                  wb_addr_q  <= rd;
                  wb_data_q  <= {{(DataW - ImmW){1'b0}}, imm9};
                  wb_alu_q   <= 1'b0;
                  state_q    <= StWb;
               end else begin
                  // NOP and undefined opcodes pass through WB as a bubble so every
                  // non-ALU instruction takes three cycles from accept to ready.
                  illegal_q <= (op != OpNop);
                  wb_alu_q  <= 1'b0;
                  state_q   <= StWb;
               end
            end
            StExec: begin
               wb_valid_q <= 1'b1;
               wb_addr_q  <= rd;
               wb_data_q  <= alu_result_i[DataW-1:0];
               wb_carry_q <= alu_result_i[DataW];
               wb_alu_q   <= 1'b1;
               alu_a_q    <= '0;
               alu_b_q    <= '0;
               alu_op_q   <= '0;
               state_q    <= StWb;
            end
            StWb: begin
               if (wb_valid_q && wb_alu_q) begin
                  zero_q  <= (wb_data_q == '0);
                  carry_q <= wb_carry_q;
               end
               instr_ready_q <= 1'b1;
               state_q       <= StIdle;
            end
         endcase
      end
   end

   assign instr_ready_o = instr_ready_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_op_o      = alu_op_q;
   assign wb_valid_o    = wb_valid_q;
   assign wb_addr_o     = wb_addr_q;
   assign wb_data_o     = wb_data_q;
   assign zero_flag_o   = zero_q;
   assign carry_flag_o  = carry_q;
   assign illegal_op_o  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a writeback scoreboard.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        zero_flag;
   logic        carry_flag;
   logic        illegal_op;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] data;
      logic        zero;
      logic        carry;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] tb_rf [8];
   logic        zero_m;
   logic        carry_m;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid_i (instr_valid),
      .instr_ready_o (instr_ready),
      .instr_i       (instr),
      .alu_a_o       (alu_a),
      .alu_b_o       (alu_b),
      .alu_op_o      (alu_op),
      .alu_result_i  (alu_result),
      .wb_valid_o    (wb_valid),
      .wb_addr_o     (wb_addr),
      .wb_data_o     (wb_data),
      .zero_flag_o   (zero_flag),
      .carry_flag_o  (carry_flag),
      .illegal_op_o  (illegal_op),
      .dbg_addr_i    (dbg_addr),
      .dbg_data_o    (dbg_data)
   );

   // Reference ALU; ADD fills the ignored upper bits with junk.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      case (op)
         OpAdd:   alu_fn = {15'h2AAA, {1'b0, a} + {1'b0, b}};
         OpSub:   alu_fn = {15'h0, {1'b0, a} - {1'b0, b}};
         OpAnd:   alu_fn = {16'h0, a & b};
         OpOr:    alu_fn = {16'h0, a | b};
         OpXor:   alu_fn = {16'h0, a ^ b};
         OpShl:   alu_fn = {15'h0, a, 1'b0};
         OpShr:   alu_fn = {16'h0, a >> 1};
         OpMul:   alu_fn = 32'(a) * 32'(b);
         OpLt:    alu_fn = {31'h0, a < b};
         OpEq:    alu_fn = {31'h0, a == b};
         default: alu_fn = 32'h0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 10) begin
         tick();
         n++;
      end
      if (!instr_ready) chk("ready_timeout", instr_ready, 1);
   endtask

   task automatic check_rf_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk(tag, dbg_data, 16'h0);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) tb_rf[i] = 16'h0;
      zero_m  = 1'b0;
      carry_m = 1'b0;
   endtask

   // Issue one ALU op or LDI, then check the writeback against the scoreboard.
   task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [8:0] imm);
      exp_t        e;
      logic [31:0] res;
      logic [15:0] word;
      logic [15:0] old;
      int          lat;
      if (op == OpLdi) word = {op, rd, imm};
      else word = {op, rd, rs1, rs2, 3'b000};
      wait_ready();
      e.addr = rd;
      if (op == OpLdi) begin
         e.data  = {7'h0, imm};
         e.zero  = zero_m;
         e.carry = carry_m;
      end else begin
         res     = alu_fn(op, tb_rf[rs1], tb_rf[rs2]);
         e.data  = res[15:0];
         e.carry = res[16];
         e.zero  = (res[15:0] == 16'h0);
      end
      sb_q.push_back(e);
      old         = tb_rf[rd];
      dbg_addr    = rd;
      instr       = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      lat = 0;
      while (!wb_valid && lat < 8) begin
         tick();
         lat++;
      end
      chk("wb_latency", lat, (op == OpLdi) ? 1 : 2);
      e = sb_q.pop_front();
      if (wb_valid) begin
         chk("wb_addr", wb_addr, e.addr);
         chk("wb_data", wb_data, e.data);
         chk("dbg_prewrite", dbg_data, old);
         tick();
         chk("wb_pulse_end", wb_valid, 0);
         chk("zero_flag", zero_flag, e.zero);
         chk("carry_flag", carry_flag, e.carry);
         if (rd != 3'd0) tb_rf[rd] = e.data;
         zero_m  = e.zero;
         carry_m = e.carry;
         chk("dbg_postwrite", dbg_data, tb_rf[rd]);
         chk("ready_after_wb", instr_ready, 1);
      end
   endtask

   // NOP or undefined opcode: no write, optional illegal pulse, ready 2 cycles after accept.
   task automatic bubble(input logic [15:0] word, input int exp_ill);
      int ill_cnt = 0;
      int wb_cnt = 0;
      int rdy_at = -1;
      wait_ready();
      instr       = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) tick();
         if (illegal_op) ill_cnt++;
         if (wb_valid) wb_cnt++;
         if (instr_ready && rdy_at < 0) rdy_at = i;
      end
      chk("bubble_illegal_cnt", ill_cnt, exp_ill);
      chk("bubble_wb_cnt", wb_cnt, 0);
      chk("bubble_ready_at", rdy_at, 2);
      chk("bubble_zero", zero_flag, zero_m);
      chk("bubble_carry", carry_flag, carry_m);
      dbg_addr = 3'd6;
      #1;
      chk("bubble_rf6", dbg_data, tb_rf[6]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc;
      logic [31:0] r;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0;
      dbg_addr    = 3'd0;
      model_reset();
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      chk("rst_ready", instr_ready, 1);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_illegal", illegal_op, 0);
      chk("rst_flags", {zero_flag, carry_flag}, 2'b00);
      chk("rst_alu", {alu_a, alu_b, alu_op}, 36'h0);
      check_rf_zero("rst_rf");

      // LDI r1,5; LDI r2,3; ADD r3,r1,r2
      issue(OpLdi, 3'd1, 3'd0, 3'd0, 9'd5);
      issue(OpLdi, 3'd2, 3'd0, 3'd0, 9'd3);
      issue(OpAdd, 3'd3, 3'd1, 3'd2, 9'd0);
      dbg_addr = 3'd3;
      #1;
      chk("add_r3_is_8", dbg_data, 16'd8);

      // Flags and operand ordering
      issue(OpSub, 3'd4, 3'd1, 3'd1, 9'd0);
      chk("sub_self_zero", zero_flag, 1);
      issue(OpSub, 3'd7, 3'd3, 3'd2, 9'd0);
      issue(OpLdi, 3'd5, 3'd0, 3'd0, 9'd511);
      issue(OpShl, 3'd6, 3'd5, 3'd0, 9'd0);
      dbg_addr = 3'd6;
      #1;
      chk("shl_r6", dbg_data, 16'h03FE);
      chk("shl_carry", carry_flag, 0);
      issue(OpLdi, 3'd1, 3'd0, 3'd0, 9'd1);
      issue(OpSub, 3'd7, 3'd0, 3'd1, 9'd0);
      issue(OpAdd, 3'd7, 3'd7, 3'd1, 9'd0);
      chk("ffff_plus_1_flags", {zero_flag, carry_flag}, 2'b11);

      // Undefined opcode and NOP
      bubble(16'hC000, 1);
      bubble(16'h0000, 0);

      // LDI to r0
      issue(OpLdi, 3'd0, 3'd0, 3'd0, 9'd7);
      dbg_addr = 3'd0;
      #1;
      chk("r0_still_zero", dbg_data, 16'h0);

      // Held instr_valid across 12 cycles of ADD r2,r1,r1
      wait_ready();
      instr       = {OpAdd, 3'd2, 3'd1, 3'd1, 3'd0};
      instr_valid = 1'b1;
      acc         = 0;
      for (int k = 0; k < 12; k++) begin
         if (instr_ready) acc++;
         tick();
      end
      instr_valid = 1'b0;
      chk("held_valid_accepts", acc, 3);
      r         = alu_fn(OpAdd, tb_rf[1], tb_rf[1]);
      tb_rf[2]  = r[15:0];
      zero_m    = (r[15:0] == 16'h0);
      carry_m   = r[16];
      dbg_addr  = 3'd2;
      #1;
      chk("held_r2", dbg_data, tb_rf[2]);
      chk("held_ready", instr_ready, 1);

      // Reset during EXEC of ADD r3,r1,r2
      wait_ready();
      instr       = {OpAdd, 3'd3, 3'd1, 3'd2, 3'd0};
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("exec_alu_op", alu_op, OpAdd);
      chk("exec_alu_a", alu_a, tb_rf[1]);
      chk("exec_alu_b", alu_b, tb_rf[2]);
      rst_n = 1'b0;
      #1;
      chk("midrst_alu_a", alu_a, 16'h0);
      chk("midrst_ready", instr_ready, 1);
      tick();
      chk("midrst_wb_valid", wb_valid, 0);
      rst_n = 1'b1;
      model_reset();
      chk("post_rst_ready", instr_ready, 1);
      tick();
      chk("post_rst_wb_valid", wb_valid, 0);
      chk("post_rst_ready2", instr_ready, 1);
      chk("post_rst_flags", {zero_flag, carry_flag}, 2'b00);
      check_rf_zero("post_rst_rf");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
